// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: default widths, reset PC and NOP encoding.
// Decode and datapath import the same defaults so the instruction format
// stays in one place.
package fetch_unit_pkg;

    localparam int unsigned DEF_INSTRUCTION_WIDTH = 18;
    localparam int unsigned DEF_PC_WIDTH          = 18;
    localparam int unsigned DEF_FIFO_DEPTH        = 2;
    localparam int unsigned DEF_RESET_PC          = 0;

    // All-zero word decodes as a no-op.
    localparam logic [DEF_INSTRUCTION_WIDTH-1:0] NOP_INST = '0;

    // Pointer width for a power-of-two queue; never narrower than one bit.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory read port, branch redirect,
// decode handshake and the starvation counter output.
// master = fetch unit side, slave = memory/branch/decode side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int unsigned PC_WIDTH          = DEF_PC_WIDTH
) ();

    logic                         o_imem_req;
    logic [PC_WIDTH-1:0]          o_imem_addr;
    logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata;
    logic                         i_redirect;
    logic [PC_WIDTH-1:0]          i_redirect_pc;
    logic                         o_valid;
    logic                         i_ready;
    logic [INSTRUCTION_WIDTH-1:0] o_inst;
    logic [PC_WIDTH-1:0]          o_inst_pc;
    logic [31:0]                  o_bubble_cnt;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_rdata,
        input  i_redirect, i_redirect_pc,
        output o_valid, o_inst, o_inst_pc,
        input  i_ready,
        output o_bubble_cnt
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_rdata,
        output i_redirect, i_redirect_pc,
        input  o_valid, o_inst, o_inst_pc,
        output i_ready,
        input  o_bubble_cnt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush. The head is read straight
// from storage registers, so the output never sees the write data path.
// Push while full is accepted only together with a pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = ptr_bits(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               wr_ptr;
    logic [CW-1:0]               count_q;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer, occupancy and storage update; flush discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited reads
// to the synchronous instruction memory, queues responses and hands them
// to decode over valid/ready. A redirect flushes queue and in-flight data.
// Optional: define FETCH_BUBBLE_CNT_EN to build the decode-starvation
// counter on o_bubble_cnt; otherwise the port reads constant zero.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int unsigned PC_WIDTH          = DEF_PC_WIDTH,
    parameter int unsigned FIFO_DEPTH        = DEF_FIFO_DEPTH,
    parameter int unsigned RESET_PC          = DEF_RESET_PC
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = PC_WIDTH + INSTRUCTION_WIDTH;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic                inflight_q;
    logic                drop_q;
    logic                running_q;
    logic                issue;
    logic                push;
    logic                pop;
    logic [CW-1:0]       occ;
    logic [CW:0]         used;
    logic                full;
    logic                empty;
    logic [EW-1:0]       head;

    // Credits: queued entries plus the one possibly in flight must leave
    // room, so a response can always be written when it arrives.
    assign used  = {1'b0, occ} + (CW + 1)'(inflight_q);
    assign issue = running_q && !bus.i_redirect && (used < DEPTH_C);

    // Response from last cycle's request; a redirect now (flush) or in the
    // previous cycle (drop) means it belongs to the abandoned stream.
    assign push = inflight_q && !drop_q && !bus.i_redirect && !full;
    assign pop  = !empty && bus.i_ready;

    assign bus.o_imem_req  = issue;
    assign bus.o_imem_addr = pc_q;
    assign bus.o_valid     = !empty;
    assign bus.o_inst_pc   = head[EW-1:INSTRUCTION_WIDTH];
    assign bus.o_inst      = head[INSTRUCTION_WIDTH-1:0];

    // PC, in-flight tracking and drop flag. running_q holds off the first
    // request until one full clock after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= PC_WIDTH'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            running_q  <= 1'b1;
            inflight_q <= issue;
            drop_q     <= bus.i_redirect;
            if (issue) begin
                req_pc_q <= pc_q;
            end
            if (bus.i_redirect) begin
                pc_q <= bus.i_redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + PC_WIDTH'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (bus.i_redirect),
        .push  (push),
        .wdata ({req_pc_q, bus.i_imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_q;

    // Count cycles where decode wanted an instruction and none was ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_q <= '0;
        end else if (running_q && bus.i_ready && empty && !bus.i_redirect
                     && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bus.o_bubble_cnt = bubble_q;
`else
    assign bus.o_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The memory responder returns
// addr+0x100. Expected output is the architectural instruction stream:
// consecutive PCs from the last reset/redirect target, each with data
// PC+0x100, queued in a scoreboard and popped on every decode transfer.
module tb_fetch_unit;

    localparam int unsigned IW = 18;
    localparam int unsigned PW = 18;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] inst;
    } exp_t;

    logic clk;
    logic rst_n;

    fetch_unit_if #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    fetch_unit #(
        .INSTRUCTION_WIDTH (IW),
        .PC_WIDTH          (PW),
        .FIFO_DEPTH        (2),
        .RESET_PC          (0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned n_xfer  = 0;

    exp_t          exp_q[$];
    logic [PW-1:0] next_pc = '0;
    logic          hold_prev = 1'b0;
    logic [PW-1:0] hold_pc;
    logic [IW-1:0] hold_inst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous instruction memory: data one cycle after the request,
    // junk otherwise so that unrequested data is never mistaken for valid.
    always @(posedge clk) begin
        if (bus.o_imem_req) bus.i_imem_rdata <= bus.o_imem_addr + 18'h100;
        else                bus.i_imem_rdata <= 18'($urandom);
    end

    // Scoreboard monitor: compare every transfer against the model stream,
    // verify head stability while stalled, restart the stream on redirect.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            next_pc   = '0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", 32'(bus.o_valid), 32'd1);
                check("stall_pc",    32'(bus.o_inst_pc), 32'(hold_pc));
                check("stall_inst",  32'(bus.o_inst), 32'(hold_inst));
            end
            if (bus.o_valid && bus.i_ready) begin
                exp_t e;
                while (exp_q.size() < 4) begin
                    exp_q.push_back('{pc: next_pc, inst: next_pc + 18'h100});
                    next_pc = next_pc + 18'd1;
                end
                e = exp_q.pop_front();
                check("xfer_pc",   32'(bus.o_inst_pc), 32'(e.pc));
                check("xfer_inst", 32'(bus.o_inst), 32'(e.inst));
`ifndef FETCH_BUBBLE_CNT_EN
                check("bubble_off", bus.o_bubble_cnt, 32'd0);
`endif
                n_xfer++;
            end
            if (bus.i_redirect) begin
                exp_q.delete();
                next_pc = bus.i_redirect_pc;
            end
            hold_prev = bus.o_valid && !bus.i_ready && !bus.i_redirect;
            hold_pc   = bus.o_inst_pc;
            hold_inst = bus.o_inst;
        end
    end

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned x0;
        logic [31:0] bub0;
        rst_n             = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(bus.o_valid), 32'd0);
        check("rst_req",    32'(bus.o_imem_req), 32'd0);
        check("rst_inst",   32'(bus.o_inst), 32'd0);
        check("rst_pc",     32'(bus.o_inst_pc), 32'd0);
        check("rst_bubble", bus.o_bubble_cnt, 32'd0);

        // Release in cycle 0; first request in cycle 1, o_valid in cycle 3.
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("c0_req", 32'(bus.o_imem_req), 32'd0);
        next_neg();
        check("c1_req",  32'(bus.o_imem_req), 32'd1);
        check("c1_addr", 32'(bus.o_imem_addr), 32'd0);
        next_neg();
        check("c2_req",   32'(bus.o_imem_req), 32'd1);
        check("c2_addr",  32'(bus.o_imem_addr), 32'd1);
        check("c2_valid", 32'(bus.o_valid), 32'd0);
        next_neg();
        check("c3_valid", 32'(bus.o_valid), 32'd1);
        check("c3_pc",    32'(bus.o_inst_pc), 32'd0);
        check("c3_inst",  32'(bus.o_inst), 32'h100);
`ifdef FETCH_BUBBLE_CNT_EN
        check("c3_bubble", bus.o_bubble_cnt, 32'd2);
`endif
        repeat (10) next_neg();

        // Stall decode for 10 cycles: queue fills, requests stop.
        @(posedge clk); #1 bus.i_ready = 1'b0;
        @(negedge clk);
        bub0 = bus.o_bubble_cnt;
        repeat (9) next_neg();
        check("full_req",   32'(bus.o_imem_req), 32'd0);
        check("full_valid", 32'(bus.o_valid), 32'd1);
        check("full_bubble_hold", bus.o_bubble_cnt, bub0);

        // Redirect with a full queue: R no request, R+1 request target,
        // R+3 target at the head.
        @(posedge clk); #1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 18'h00040;
        @(negedge clk);
        check("redir_R_req", 32'(bus.o_imem_req), 32'd0);
        @(posedge clk); #1 bus.i_redirect = 1'b0;
        @(negedge clk);
        check("redir_R1_valid", 32'(bus.o_valid), 32'd0);
        check("redir_R1_req",   32'(bus.o_imem_req), 32'd1);
        check("redir_R1_addr",  32'(bus.o_imem_addr), 32'h40);
        next_neg();
        check("redir_R2_valid", 32'(bus.o_valid), 32'd0);
        next_neg();
        check("redir_R3_valid", 32'(bus.o_valid), 32'd1);
        check("redir_R3_pc",    32'(bus.o_inst_pc), 32'h40);
        @(posedge clk); #1 bus.i_ready = 1'b1;

        // PC wrap: stream 0x3FFFE, 0x3FFFF, 0x00000 checked by the scoreboard.
        @(posedge clk); #1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 18'h3FFFE;
        @(posedge clk); #1 bus.i_redirect = 1'b0;
        x0 = n_xfer;
        repeat (12) next_neg();
        check("wrap_progress", 32'(n_xfer - x0 >= 3), 32'd1);

        // Random ready/redirect traffic with one mid-run reset.
        x0 = n_xfer;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            bus.i_ready    = ($urandom_range(0, 3) != 0);
            bus.i_redirect = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.i_redirect_pc = 18'h3FFFC + 18'($urandom_range(0, 7));
            else
                bus.i_redirect_pc = 18'($urandom);
            if (i == 1000) begin
                rst_n = 1'b0;
                #2;
                check("midrst_valid", 32'(bus.o_valid), 32'd0);
                check("midrst_req",   32'(bus.o_imem_req), 32'd0);
                check("midrst_pc",    32'(bus.o_inst_pc), 32'd0);
                check("midrst_inst",  32'(bus.o_inst), 32'd0);
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        bus.i_redirect = 1'b0;
        bus.i_ready    = 1'b1;
        repeat (6) next_neg();
        check("random_progress", 32'(n_xfer - x0 >= 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
